// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard renderer.
// Glyphs are drawn seven-segment style on an 11x11 cell.
package placar_pkg;

  localparam int NUM_DIGITS = 7;
  localparam int GLYPH_W    = 11;
  localparam int GLYPH_H    = 11;

  typedef logic [3:0] digito_t;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  // Segment set {a,b,c,d,e,f,g} for each BCD value; non-BCD codes light nothing
  function automatic logic [6:0] segments(input digito_t d);
    case (d)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/glyph_rom_11x11.sv
// Combinational 11x11 glyph ROM: one 11-bit row mask per (digit, row).
// Bit 10 is the leftmost column of the glyph.
module glyph_rom_11x11
  import placar_pkg::*;
(
  input  digito_t     digit,
  input  logic [3:0]  row,
  output logic [10:0] mask
);

  localparam logic [10:0] BAR   = 11'b01111111110;
  localparam logic [10:0] LEFT  = 11'b10000000000;
  localparam logic [10:0] RIGHT = 11'b00000000001;

  logic [6:0] seg;

  assign seg = segments(digit);

  // Rows 0/5/10 carry the horizontal bars; rows between carry the verticals
  always_comb begin
    mask = '0;
    case (row)
      4'd0:                   mask = seg[6] ? BAR : '0;
      4'd1, 4'd2, 4'd3, 4'd4: mask = (seg[1] ? LEFT : '0) | (seg[5] ? RIGHT : '0);
      4'd5:                   mask = seg[0] ? BAR : '0;
      4'd6, 4'd7, 4'd8, 4'd9: mask = (seg[2] ? LEFT : '0) | (seg[4] ? RIGHT : '0);
      4'd10:                  mask = seg[3] ? BAR : '0;
      default:                mask = '0;
    endcase
  end

endmodule

// File: rtl/renderiza_placar.sv
// Renders seven BCD score digits as 11x11 glyphs, one pixel per
// valid/ready transfer, scanning digit 7 down to 1, row by row.
module renderiza_placar
  import placar_pkg::*;
#(
  parameter logic [9:0] ORIGIN_X    = 10'd0,
  parameter logic [8:0] ORIGIN_Y    = 9'd0,
  parameter int         DIGIT_PITCH = 12,
  parameter logic [7:0] FG_COLOR    = 8'hFF,
  parameter logic [7:0] BG_COLOR    = 8'h00
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] digito [7:1],
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic [7:0] pix_color,
  output logic       busy,
  output logic       done
);

  state_t      state;
  digito_t     sh [NUM_DIGITS];
  logic [2:0]  dig_cnt;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  col_nxt;
  logic [10:0] mask_q;
  logic [10:0] rom_mask;
  logic [9:0]  base_x;

  assign col_nxt = col + 4'd1;

  // The digit being drawn always sits at the top of the shift register
  glyph_rom_11x11 u_rom (
    .digit (sh[NUM_DIGITS-1]),
    .row   (row),
    .mask  (rom_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < NUM_DIGITS; i++) sh[i] <= '0;
      dig_cnt   <= '0;
      row       <= '0;
      col       <= '0;
      mask_q    <= '0;
      base_x    <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < NUM_DIGITS; i++) sh[i] <= digito[i+1];
            dig_cnt <= '0;
            row     <= '0;
            col     <= '0;
            base_x  <= ORIGIN_X;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          mask_q    <= rom_mask;
          col       <= '0;
          pix_x     <= base_x;
          pix_y     <= ORIGIN_Y + 9'(row);
          pix_color <= rom_mask[GLYPH_W-1] ? FG_COLOR : BG_COLOR;
          pix_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (pix_ready) begin
            if (col == 4'(GLYPH_W-1)) begin
              pix_valid <= 1'b0;
              col       <= '0;
              if (row == 4'(GLYPH_H-1)) begin
                row <= '0;
                if (dig_cnt == 3'(NUM_DIGITS-1)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
                end else begin
                  dig_cnt <= dig_cnt + 3'd1;
                  for (int i = NUM_DIGITS-1; i > 0; i--) sh[i] <= sh[i-1];
                  sh[0]   <= '0;
                  base_x  <= base_x + 10'(DIGIT_PITCH);
                  state   <= FETCH;
                end
              end else begin
                row   <= row + 4'd1;
                state <= FETCH;
              end
            end else begin
              col       <= col_nxt;
              pix_x     <= pix_x + 10'd1;
              pix_color <= mask_q[4'd10 - col_nxt] ? FG_COLOR : BG_COLOR;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/renderiza_placar.md
RENDERIZA_PLACAR -- requirements
Module: renderiza_placar

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 10'd0: x of the top-left pixel of the leftmost digit (digit 7).
REQ-002 SHALL have parameter ORIGIN_Y, default 9'd0: y of the top row of every digit.
REQ-003 SHALL have parameter DIGIT_PITCH, default 12: horizontal distance in pixels between digit origins.
REQ-004 SHALL have parameters FG_COLOR, default 8'hFF, and BG_COLOR, default 8'h00: colours of set and clear glyph pixels.
REQ-005 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to render a frame.
REQ-009 SHALL have port digito[7:1], input, 7 x 4 bits: BCD score digits, sampled on the start cycle only.
REQ-010 SHALL have port pix_valid, output, 1 bit: a pixel write is offered.
REQ-011 SHALL have port pix_ready, input, 1 bit: the sink accepts the offered pixel.
REQ-012 SHALL have ports pix_x, output, 10 bits; pix_y, output, 9 bits; pix_color, output, 8 bits: pixel coordinates and colour.
REQ-013 SHALL have ports busy, output, 1 bit: high from the start acceptance until done; and done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL accept start only in IDLE, latching all seven digits; start in any other state SHALL be ignored.
REQ-015 SHALL implement four states: IDLE, FETCH, EMIT, DONE.
REQ-016 SHALL sequence IDLE -(start)-> FETCH -> EMIT -(row complete, more rows)-> FETCH; after the last pixel of the last row it SHALL go to DONE, then IDLE.
REQ-017 SHALL, in FETCH, register the 11-bit row mask for the current digit and row from the glyph ROM; this costs one cycle per row.
REQ-018 SHALL scan digits 7 down to 1, rows 0 to 10 per digit, and columns 0 to 10 per row: 7 x 11 x 11 = 847 pixels.
REQ-019 SHALL compute pix_x = ORIGIN_X + (7-k)*DIGIT_PITCH + col and pix_y = ORIGIN_Y + row, with modulo-2^width wrap and no saturation.
REQ-020 SHALL set pix_color = FG_COLOR when mask bit (10-col) is 1, and BG_COLOR otherwise.
REQ-021 SHALL render a digit value of 10 to 15 as all BG_COLOR (121 pixels).
REQ-022 SHALL assert pix_valid only in EMIT.
REQ-023 SHALL complete a transfer only on a cycle with pix_valid=1 and pix_ready=1.
REQ-024 SHALL hold pix_x, pix_y and pix_color stable while pix_valid=1 and pix_ready=0.
REQ-025 SHALL assert the first pix_valid two cycles after the start cycle, given that start is sampled at edge N, FETCH runs in cycle N+1 and EMIT begins at N+2.
REQ-026 SHALL, with pix_ready held at 1, pulse done exactly 924 cycles after the start edge (77 rows x 12 cycles) and drop busy in the same cycle.
REQ-027 SHALL ignore changes on digito during a frame.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE, all counters to 0, and pix_valid, busy, done, pix_x, pix_y and pix_color to 0.
REQ-029 SHALL, on reset during a frame, abort the frame without a done pulse; the next start SHALL restart at digit 7, row 0, column 0.

Structure
REQ-030 SHALL place in shared package placar_pkg: NUM_DIGITS=7, GLYPH_W=11, GLYPH_H=11, typedef digito_t (4-bit), and the state enum.
REQ-031 SHALL use one sub-module glyph_rom_11x11: inputs digit and row (0-10), output an 11-bit row mask; index 10 to 15 returns 0; it is combinational and registered by the caller in FETCH.

Verification
REQ-032 SHALL test: all digits 0, pix_ready=1 -> 847 transfers; first at (ORIGIN_X, ORIGIN_Y); last at (ORIGIN_X+82, ORIGIN_Y+10); done 924 cycles after start.
REQ-033 SHALL test: digit 7 = 4'hF, others 8 -> first 121 pixels all BG_COLOR; remaining pixels match the ROM for digit 8.
REQ-034 SHALL test: pix_ready random with 50% duty -> fields stable under stall; transfer sequence identical to REQ-032; exactly one done.
REQ-035 SHALL test: start pulsed again mid-frame and digito changed mid-frame -> no effect; 847 transfers; one done.
REQ-036 SHALL test: rst_n low after transfer 300 -> pix_valid and busy 0 without waiting for a clock edge; no done; the next start's first pixel is at (ORIGIN_X, ORIGIN_Y).
